// File: rtl/uart_display_pkg.sv
// Shared constants, parser state encoding and the ASCII hex-digit decoder
// for the UART display controller.
package uart_display_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } parse_state_e;

    // Returns {valid, nibble}; valid is 0 for anything that is not a hex digit.
    function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, 4'(c - 8'h30)};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, 4'(c - 8'h37)};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            r = {1'b1, 4'(c - 8'h57)};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_display_ctrl_en_gen.sv
// Free-running divider that produces the one-cycle oversample enable for uart_rx.
module uart_en_gen #(
    parameter int CLK_DIVIDER = 64,
    parameter int EN_PHASE    = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_uart_en
);

    localparam int CW = (CLK_DIVIDER > 2) ? $clog2(CLK_DIVIDER) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIVIDER - 1);
    localparam logic [CW-1:0] CNT_PHASE = CW'(EN_PHASE);

    logic [CW-1:0] counter_q, counter_d;
    logic          en_q, en_d;

    always_comb begin
        counter_d = (counter_q == CNT_LAST) ? '0 : counter_q + 1'b1;
        en_d      = (counter_q == CNT_PHASE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            counter_q <= '0;
            en_q      <= 1'b0;
        end else begin
            counter_q <= counter_d;
            en_q      <= en_d;
        end
    end

    assign o_uart_en = en_q;

endmodule

// File: rtl/uart_display_ctrl.sv
// UART-to-seven-segment glue: enable generator, raw byte shifter and, when
// UART_DISPLAY_ASCII_EN is defined, an ASCII hex line parser with commit/edit/clear.
module uart_display_ctrl
    import uart_display_pkg::*;
#(
    parameter int CLK_DIVIDER = 64,
    parameter int EN_PHASE    = 10,
    parameter int N_DIGITS    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_ascii_mode,
    output logic                  o_uart_en,
    output logic [4*N_DIGITS-1:0] o_display_data,
    output logic                  o_display_update,
    output logic                  o_err
);

    localparam int DW = 4 * N_DIGITS;

    uart_en_gen #(
        .CLK_DIVIDER (CLK_DIVIDER),
        .EN_PHASE    (EN_PHASE)
    ) u_en_gen (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .o_uart_en (o_uart_en)
    );

    logic [DW-1:0] display_q, display_d;
    logic          update_q, update_d;
    logic          err_q, err_d;

    // Newest byte lands in the low two digits; the cast drops the oldest byte.
    logic [DW-1:0] raw_shift;
    assign raw_shift = DW'({display_q, i_rx_data});

`ifdef UART_DISPLAY_ASCII_EN
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_DIGITS);

    parse_state_e  state_q, state_d;
    logic [DW-1:0] staging_q, staging_d;
    logic [CW-1:0] count_q, count_d;
    logic          mode_q;
    logic [4:0]    nib;

    always_comb begin
        display_d = display_q;
        update_d  = 1'b0;
        err_d     = 1'b0;
        staging_d = staging_q;
        count_d   = count_q;
        state_d   = state_q;
        nib       = ascii_to_nibble(i_rx_data);

        // A mode switch abandons any partial line; a byte arriving that same cycle is dropped.
        if (i_ascii_mode != mode_q) begin
            staging_d = '0;
            count_d   = '0;
            state_d   = ST_IDLE;
        end else if (i_rx_valid) begin
            if (!i_ascii_mode) begin
                display_d = raw_shift;
                update_d  = 1'b1;
            end else if (nib[4]) begin
                staging_d = DW'({staging_q, nib[3:0]});
                if (count_q != CNT_MAX) count_d = count_q + 1'b1;
                state_d   = ST_ACCUM;
            end else begin
                case (i_rx_data)
                    ASCII_CR, ASCII_LF: begin
                        if (state_q == ST_ACCUM) begin
                            display_d = staging_q;
                            update_d  = 1'b1;
                            staging_d = '0;
                            count_d   = '0;
                            state_d   = ST_IDLE;
                        end
                    end
                    ASCII_BS: begin
                        if (count_q != '0) begin
                            staging_d = staging_q >> 4;
                            count_d   = count_q - 1'b1;
                            if (count_q == CW'(1)) state_d = ST_IDLE;
                        end
                    end
                    ASCII_ESC: begin
                        display_d = '0;
                        update_d  = 1'b1;
                        staging_d = '0;
                        count_d   = '0;
                        state_d   = ST_IDLE;
                    end
                    default: begin
                        err_d     = 1'b1;
                        staging_d = '0;
                        count_d   = '0;
                        state_d   = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            display_q <= '0;
            update_q  <= 1'b0;
            err_q     <= 1'b0;
            staging_q <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
        end else begin
            display_q <= display_d;
            update_q  <= update_d;
            err_q     <= err_d;
            staging_q <= staging_d;
            count_q   <= count_d;
            state_q   <= state_d;
            mode_q    <= i_ascii_mode;
        end
    end
`else
    logic unused_ascii_mode;
    assign unused_ascii_mode = i_ascii_mode;

    always_comb begin
        display_d = display_q;
        update_d  = 1'b0;
        err_d     = 1'b0;
        if (i_rx_valid) begin
            display_d = raw_shift;
            update_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            display_q <= '0;
            update_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            display_q <= display_d;
            update_q  <= update_d;
            err_q     <= err_d;
        end
    end
`endif

    assign o_display_data   = display_q;
    assign o_display_update = update_q;
    assign o_err            = err_q;

endmodule

// File: tb/tb_uart_display_ctrl.sv
// Scoreboard bench for uart_display_ctrl: expected update/err events are queued as
// bytes are driven and compared against events captured from the outputs.
module tb_uart_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        ascii_mode = 1'b0;
    logic        uart_en;
    logic [15:0] disp;
    logic        upd;
    logic        err;

    uart_display_ctrl #(.CLK_DIVIDER(64), .EN_PHASE(10), .N_DIGITS(4)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_rx_data        (rx_data),
        .i_rx_valid       (rx_valid),
        .i_ascii_mode     (ascii_mode),
        .o_uart_en        (uart_en),
        .o_display_data   (disp),
        .o_display_update (upd),
        .o_err            (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        upd;
        logic        err;
        logic [15:0] data;
        logic [31:0] cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t mon_ev;
    int  cyc = 0;
    int  last_cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && (upd || err)) begin
            mon_ev.upd  = upd;
            mon_ev.err  = err;
            mon_ev.data = disp;
            mon_ev.cyc  = cyc;
            obs_q.push_back(mon_ev);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic push_exp(input logic u, input logic e, input logic [15:0] d);
        ev_t x;
        x.upd = u; x.err = e; x.data = d; x.cyc = last_cyc;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({uart_en, disp, upd, err} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b disp=%h upd=%b err=%b, need all 0", uart_en, disp, upd, err);
        end
    endtask

    task automatic test_divider();
        do_reset();
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (uart_en !== (k == 11 || k == 75 || k == 139)) begin
                n_err++;
                $display("FAIL divider cycle %0d: got en=%b, need %b", k, uart_en, (k == 11 || k == 75 || k == 139));
            end
        end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (uart_en !== 1'b0) begin
            n_err++;
            $display("FAIL divider_in_reset: got en=%b, need 0", uart_en);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (uart_en !== (k == 11 || k == 75)) begin
                n_err++;
                $display("FAIL divider_restart cycle %0d: got en=%b, need %b", k, uart_en, (k == 11 || k == 75));
            end
        end
    endtask

    task automatic test_raw();
        ev_t e, o;
        do_reset();
        ascii_mode = 1'b0;
        repeat (2) @(negedge clk);
        strobe(8'h12); push_exp(1'b1, 1'b0, 16'h0012);
        strobe(8'h34); push_exp(1'b1, 1'b0, 16'h1234);
        strobe(8'hAB); push_exp(1'b1, 1'b0, 16'h34AB);
        repeat (4) @(negedge clk);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_vec++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_err++;
                $display("FAIL raw_count: got %0d events left, need %0d", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL raw_event: got upd=%b err=%b data=%h cyc=%0d, need upd=%b err=%b data=%h cyc=%0d",
                             o.upd, o.err, o.data, o.cyc, e.upd, e.err, e.data, e.cyc);
                end
            end
        end
    endtask

`ifdef UART_DISPLAY_ASCII_EN
    task automatic test_ascii();
        ev_t e, o;
        do_reset();
        ascii_mode = 1'b1;
        repeat (3) @(negedge clk);
        // commit, then a CR on an empty line must stay silent
        strobe("1"); strobe("a"); strobe("F");
        strobe(8'h0D); push_exp(1'b1, 1'b0, 16'h01AF);
        strobe(8'h0D);
        // overflow drops the oldest digit, backspace trims the newest
        strobe("1"); strobe("2"); strobe("3"); strobe("4"); strobe("5");
        strobe(8'h08);
        strobe(8'h0A); push_exp(1'b1, 1'b0, 16'h0234);
        strobe("7"); strobe(8'h08); strobe(8'h08); strobe(8'h0D);
        // illegal char flags an error without touching the display
        strobe("9");
        strobe("G"); push_exp(1'b0, 1'b1, 16'h0234);
        strobe(8'h0D);
        strobe(8'h1B); push_exp(1'b1, 1'b0, 16'h0000);
        // toggling the mode throws away a partial line
        strobe("5");
        @(negedge clk) ascii_mode = 1'b0;
        @(negedge clk) ascii_mode = 1'b1;
        repeat (2) @(negedge clk);
        strobe(8'h0D);
        repeat (4) @(negedge clk);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_vec++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_err++;
                $display("FAIL ascii_count: got %0d events left, need %0d", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL ascii_event: got upd=%b err=%b data=%h cyc=%0d, need upd=%b err=%b data=%h cyc=%0d",
                             o.upd, o.err, o.data, o.cyc, e.upd, e.err, e.data, e.cyc);
                end
            end
        end
    endtask
`else
    task automatic test_config();
        ev_t e, o;
        do_reset();
        ascii_mode = 1'b1;
        repeat (2) @(negedge clk);
        strobe("A"); push_exp(1'b1, 1'b0, 16'h0041);
        strobe("G"); push_exp(1'b1, 1'b0, 16'h4147);
        repeat (4) @(negedge clk);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_vec++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_err++;
                $display("FAIL config_count: got %0d events left, need %0d", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL config_event: got upd=%b err=%b data=%h cyc=%0d, need upd=%b err=%b data=%h cyc=%0d",
                             o.upd, o.err, o.data, o.cyc, e.upd, e.err, e.data, e.cyc);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_divider();
        test_raw();
`ifdef UART_DISPLAY_ASCII_EN
        test_ascii();
`else
        test_config();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
